// File: rtl/gray_frame_sched.sv
// Ping-pong frame-buffer scheduler: writes the current gray frame to one bank, reads the previous good frame from the other.
// Latency: mem ports 1 cycle, pairs RD_LAT+2 cycles after the pixel; no backpressure, one pixel per cycle is sustained.
module gray_frame_sched #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              gray_vsync,
    input  logic              gray_href,
    input  logic              gray_valid,
    input  logic [7:0]        gray_data,
    output logic              mem_wr_en,
    output logic              mem_wr_bank,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              mem_rd_en,
    output logic              mem_rd_bank,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              pair_valid,
    output logic              pair_vsync,
    output logic              pair_href,
    output logic [7:0]        cur_data,
    output logic [7:0]        prev_data,
    output logic              diff_en,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int LINE_W = $clog2(V_ACT + 1) + 1;
    localparam logic [CNT_W-1:0]  FRAME_PIX = CNT_W'(H_ACT * V_ACT);
    localparam logic [CNT_W-1:0]  H_ACT_C   = CNT_W'(H_ACT);
    localparam logic [LINE_W-1:0] V_ACT_C   = LINE_W'(V_ACT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_ACTIVE,
        S_CHECK
    } state_t;

    typedef struct packed {
        logic       vld;
        logic       vs;
        logic       hr;
        logic       rd;
        logic [7:0] dat;
    } pipe_t;

    state_t              state_q, state_d;
    logic                vsync_q, href_q;
    logic [CNT_W-1:0]    pix_addr_q, pix_addr_d;
    logic [CNT_W-1:0]    line_pix_q, line_pix_d;
    logic [CNT_W-1:0]    line_pix_inc;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                line_bad_q, line_bad_d;
    logic                ovf_q, ovf_d;
    logic                bank_q, bank_d;
    logic                diff_en_q, diff_en_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

    pipe_t               dly_q [0:RD_LAT];
    pipe_t               stage_in;
    logic                pair_valid_q, pair_vsync_q, pair_href_q;
    logic [7:0]          cur_data_q, prev_data_q;

    logic boundary, href_fall, accept, room, do_wr, frame_good;

    assign boundary   = gray_vsync & ~vsync_q;
    assign href_fall  = href_q & ~gray_href;
    assign accept     = (state_q == S_ACTIVE) & gray_valid & ~gray_vsync;
    assign room       = (pix_addr_q < FRAME_PIX);
    assign do_wr      = accept & room;
    assign frame_good = (line_cnt_q == V_ACT_C) && (pix_addr_q == FRAME_PIX)
                        && !line_bad_q && !ovf_q;
    assign line_pix_inc = line_pix_q + {{(CNT_W-1){1'b0}}, accept};

    always_comb begin
        state_d     = state_q;
        pix_addr_d  = pix_addr_q;
        line_pix_d  = line_pix_q;
        line_cnt_d  = line_cnt_q;
        line_bad_d  = line_bad_q;
        ovf_d       = ovf_q;
        bank_d      = bank_q;
        diff_en_d   = diff_en_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_en_d     = do_wr;
        wr_addr_d   = do_wr ? pix_addr_q[ADDR_W-1:0] : wr_addr_q;
        wr_data_d   = do_wr ? gray_data : wr_data_q;
        rd_en_d     = do_wr & diff_en_q;
        rd_addr_d   = (do_wr & diff_en_q) ? pix_addr_q[ADDR_W-1:0] : rd_addr_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (boundary) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (room) pix_addr_d = pix_addr_q + 1'b1;
                    else      ovf_d      = 1'b1;
                end
                // The pixel landing on the falling-edge cycle still belongs to the closing line.
                if (href_fall) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                    line_pix_d = '0;
                    if (line_pix_inc != H_ACT_C) line_bad_d = 1'b1;
                end else begin
                    line_pix_d = line_pix_inc;
                end
                if (boundary) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (frame_good) begin
                    bank_d      = ~bank_q;
                    diff_en_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    done_d      = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                pix_addr_d = '0;
                line_pix_d = '0;
                line_cnt_d = '0;
                line_bad_d = 1'b0;
                ovf_d      = 1'b0;
                state_d    = enable ? S_ACTIVE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pix_addr_q  <= '0;
            line_pix_q  <= '0;
            line_cnt_q  <= '0;
            line_bad_q  <= 1'b0;
            ovf_q       <= 1'b0;
            bank_q      <= 1'b0;
            diff_en_q   <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= gray_vsync;
            href_q      <= gray_href;
            pix_addr_q  <= pix_addr_d;
            line_pix_q  <= line_pix_d;
            line_cnt_q  <= line_cnt_d;
            line_bad_q  <= line_bad_d;
            ovf_q       <= ovf_d;
            bank_q      <= bank_d;
            diff_en_q   <= diff_en_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Stage 0 lines up with the registered read strobe; stage RD_LAT with the returning read data.
    always_comb begin
        stage_in     = '0;
        stage_in.vld = accept;
        stage_in.vs  = gray_vsync;
        stage_in.hr  = gray_href;
        stage_in.rd  = rd_en_d;
        stage_in.dat = gray_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) dly_q[i] <= '0;
            pair_valid_q <= 1'b0;
            pair_vsync_q <= 1'b0;
            pair_href_q  <= 1'b0;
            cur_data_q   <= '0;
            prev_data_q  <= '0;
        end else begin
            dly_q[0] <= stage_in;
            for (int i = 1; i <= RD_LAT; i++) dly_q[i] <= dly_q[i-1];
            pair_valid_q <= dly_q[RD_LAT].vld;
            pair_vsync_q <= dly_q[RD_LAT].vs;
            pair_href_q  <= dly_q[RD_LAT].hr;
            cur_data_q   <= dly_q[RD_LAT].dat;
            prev_data_q  <= dly_q[RD_LAT].rd ? mem_rd_data : dly_q[RD_LAT].dat;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_bank = bank_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_bank = ~bank_q;
    assign mem_rd_addr = rd_addr_q;
    assign pair_valid  = pair_valid_q;
    assign pair_vsync  = pair_vsync_q;
    assign pair_href   = pair_href_q;
    assign cur_data    = cur_data_q;
    assign prev_data   = prev_data_q;
    assign diff_en     = diff_en_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_gray_frame_sched.sv
// Directed bench for gray_frame_sched at 4x3 pixels, RD_LAT=1, with a two-bank memory model.
module tb_gray_frame_sched;
    localparam int H = 4, V = 3, AW = 4, NPIX = H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, gray_vsync, gray_href, gray_valid;
    logic [7:0]    gray_data;
    logic          mem_wr_en, mem_wr_bank, mem_rd_en, mem_rd_bank;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [7:0]    mem_wr_data, mem_rd_data;
    logic          pair_valid, pair_vsync, pair_href, diff_en, frame_done, frame_err;
    logic [7:0]    cur_data, prev_data;
    logic [15:0]   frame_cnt;

    gray_frame_sched #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .gray_vsync(gray_vsync), .gray_href(gray_href), .gray_valid(gray_valid), .gray_data(gray_data),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .pair_valid(pair_valid), .pair_vsync(pair_vsync), .pair_href(pair_href),
        .cur_data(cur_data), .prev_data(prev_data), .diff_en(diff_en),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_wr_en) mem[{mem_wr_bank, mem_wr_addr}] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[{mem_rd_bank, mem_rd_addr}];
    end

    typedef struct {
        logic       vld;
        logic       vs;
        logic       hr;
        logic [7:0] cur;
        logic [7:0] prev;
    } exp_pair_t;

    typedef struct {
        int         kind;   // 0 clean, 1 short line, 2 thirteen pixels, 3 valid during closing vsync
        logic [7:0] base;
        logic       done;
        logic       err;
        logic       bank;
        logic       diff;
        logic [15:0] cnt;
    } frame_vec_t;

    exp_pair_t  pq[$];
    int         checks = 0, errors = 0;
    logic       exp_active, exp_bank, exp_diff, pulse_done, pulse_err;
    logic [15:0] exp_cnt;
    int         exp_addr;
    logic [7:0] good_mem [NPIX];
    logic [7:0] cur_mem  [NPIX];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic vs, input logic hr, input logic vl, input logic [7:0] d);
        exp_pair_t p;
        logic acc, wr;
        gray_vsync = vs; gray_href = hr; gray_valid = vl; gray_data = d;
        acc = exp_active && vl && !vs;
        wr  = acc && (exp_addr < NPIX);
        p.vld = acc; p.vs = vs; p.hr = hr; p.cur = d;
        p.prev = (wr && exp_diff) ? good_mem[exp_addr] : d;
        pq.push_back(p);
        @(posedge clk); #1;
        chk("wr_en", mem_wr_en, wr);
        if (wr) begin
            chk("wr_addr", mem_wr_addr, exp_addr);
            chk("wr_data", mem_wr_data, d);
        end
        chk("rd_en", mem_rd_en, wr && exp_diff);
        if (wr && exp_diff) chk("rd_addr", mem_rd_addr, exp_addr);
        chk("wr_bank", mem_wr_bank, exp_bank);
        chk("rd_bank", mem_rd_bank, !exp_bank);
        chk("frame_done", frame_done, pulse_done);
        chk("frame_err", frame_err, pulse_err);
        if (wr) begin
            cur_mem[exp_addr] = d;
            exp_addr++;
        end
        if (pq.size() == 3) begin
            p = pq.pop_front();
            chk("pair_valid", pair_valid, p.vld);
            chk("pair_vsync", pair_vsync, p.vs);
            chk("pair_href", pair_href, p.hr);
            if (p.vld) begin
                chk("cur_data", cur_data, p.cur);
                chk("prev_data", prev_data, p.prev);
            end
        end
    endtask

    task automatic body(input int kind, input logic [7:0] base);
        int idx = 0;
        for (int l = 0; l < V; l++) begin
            int n = (kind == 1 && l == 1) ? 3 : H;
            for (int i = 0; i < n; i++) begin
                cyc(1'b0, 1'b1, 1'b1, base + 8'(idx));
                idx++;
            end
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
        end
        if (kind == 2) cyc(1'b0, 1'b0, 1'b1, base + 8'(idx));
    endtask

    // Pulses and the bank swap land together two cycles after vsync rises.
    task automatic close(input int kind, input logic done_e, input logic err_e);
        logic jv = (kind == 3);
        cyc(1'b1, 1'b0, jv, 8'hEE);
        pulse_done = done_e; pulse_err = err_e;
        if (done_e) begin
            exp_bank = !exp_bank;
            exp_diff = 1'b1;
            exp_cnt  = exp_cnt + 16'd1;
            for (int i = 0; i < NPIX; i++) good_mem[i] = cur_mem[i];
        end
        cyc(1'b1, 1'b0, jv, 8'hEE);
        pulse_done = 1'b0; pulse_err = 1'b0;
        cyc(1'b1, 1'b0, jv, 8'hEE);
        exp_addr = 0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1; gray_vsync = 1'b0; gray_href = 1'b0; gray_valid = 1'b0; gray_data = 8'h00;
        pq.delete();
        exp_active = 1'b0; exp_bank = 1'b0; exp_diff = 1'b0; exp_cnt = 16'd0; exp_addr = 0;
        pulse_done = 1'b0; pulse_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst wr_en", mem_wr_en, 0);   chk("rst wr_bank", mem_wr_bank, 0);
        chk("rst wr_addr", mem_wr_addr, 0); chk("rst wr_data", mem_wr_data, 0);
        chk("rst rd_en", mem_rd_en, 0);   chk("rst rd_addr", mem_rd_addr, 0);
        chk("rst rd_bank", mem_rd_bank, 1);
        chk("rst pair_valid", pair_valid, 0); chk("rst pair_vsync", pair_vsync, 0);
        chk("rst pair_href", pair_href, 0);   chk("rst cur", cur_data, 0);
        chk("rst prev", prev_data, 0);        chk("rst diff_en", diff_en, 0);
        chk("rst done", frame_done, 0);       chk("rst err", frame_err, 0);
        chk("rst frame_cnt", frame_cnt, 0);
    endtask

    task automatic chk_state(input string nm, input logic bank, input logic diff, input logic [15:0] cnt);
        chk({nm, " bank"}, mem_wr_bank, bank);
        chk({nm, " diff_en"}, diff_en, diff);
        chk({nm, " frame_cnt"}, frame_cnt, cnt);
    endtask

    frame_vec_t vec [7];

    initial begin
        vec[0] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        vec[1] = '{0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
        vec[2] = '{1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
        vec[3] = '{0, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3};
        vec[4] = '{2, 8'h30, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3};
        vec[5] = '{3, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4};
        vec[6] = '{0, 8'h50, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5};

        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Partial frame seen while syncing: no writes, no pulse.
        body(0, 8'hA0);
        close(0, 1'b0, 1'b0);
        chk_state("sync", 1'b0, 1'b0, 16'd0);
        exp_active = 1'b1;

        for (int r = 0; r < 7; r++) begin
            body(vec[r].kind, vec[r].base);
            close(vec[r].kind, vec[r].done, vec[r].err);
            chk_state($sformatf("vec%0d", r), vec[r].bank, vec[r].diff, vec[r].cnt);
        end

        // Enable dropped mid-frame: frame still checked, then idle holds state.
        enable = 1'b0;
        body(0, 8'h60);
        close(0, 1'b1, 1'b0);
        exp_active = 1'b0;
        chk_state("disable", 1'b0, 1'b1, 16'd6);
        body(0, 8'h70);
        close(0, 1'b0, 1'b0);
        chk_state("idle", 1'b0, 1'b1, 16'd6);

        enable = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        body(0, 8'h80);
        close(0, 1'b0, 1'b0);
        exp_active = 1'b1;

        // Reset in the middle of a frame abandons it.
        for (int i = 0; i < H; i++) cyc(1'b0, 1'b1, 1'b1, 8'hC0 + 8'(i));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'hC4);
        cyc(1'b0, 1'b1, 1'b1, 8'hC5);
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        body(0, 8'hB0);
        close(0, 1'b0, 1'b0);
        exp_active = 1'b1;
        body(0, 8'h90);
        close(0, 1'b1, 1'b0);
        chk_state("post-rst1", 1'b1, 1'b1, 16'd1);
        body(0, 8'h9A);
        close(0, 1'b1, 1'b0);
        chk_state("post-rst2", 1'b0, 1'b1, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
